// File: rtl/tc_kloop_sequencer.sv
// K-loop sequencer for the shared 4x4 tensor core: latches C0, feeds A_k/B_k tile pairs
// from a valid/ready stream and chains core_d back into core_c until num_k pairs are consumed.
//
// state   | meaning
// IDLE    | waiting for start; num_k and c_in sampled here
// WAIT_OP | op_ready high, waiting for the next A/B tile pair
// EXEC    | operands held on the core, waiting CORE_LAT cycles to capture core_d
// FIN     | done pulse, final accumulator copied to d_out
module tc_kloop_sequencer #(
    parameter int KSTEPS_MAX = 16,
    parameter int CNT_W      = 5,
    parameter int CORE_LAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_k,
    input  logic [511:0]     c_in,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [255:0]     a_in,
    input  logic [255:0]     b_in,
    output logic [255:0]     core_a,
    output logic [255:0]     core_b,
    output logic [511:0]     core_c,
    input  logic [511:0]     core_d,
    output logic             busy,
    output logic             done,
    output logic [511:0]     d_out,
    output logic             err
);

    localparam int ECNT_W = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_OP = 2'd1,
        EXEC    = 2'd2,
        FIN     = 2'd3
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    kcnt;
    logic [CNT_W-1:0]    num_k_q;
    logic [ECNT_W-1:0]   ecnt;
    logic [511:0]        d_out_q;

    assign op_ready = (state == WAIT_OP);

    // done is high exactly while in FIN, so the bypass shows the result in the done cycle
    assign d_out = done ? core_c : d_out_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            kcnt    <= '0;
            num_k_q <= '0;
            ecnt    <= '0;
            core_a  <= '0;
            core_b  <= '0;
            core_c  <= '0;
            d_out_q <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (num_k > CNT_W'(KSTEPS_MAX)) begin
                            err <= 1'b1;
                        end else begin
                            core_c  <= c_in;
                            kcnt    <= '0;
                            num_k_q <= num_k;
                            busy    <= 1'b1;
                            if (num_k == '0) begin
                                state <= FIN;
                                done  <= 1'b1;
                            end else begin
                                state <= WAIT_OP;
                            end
                        end
                    end
                end
                WAIT_OP: begin
                    if (op_valid) begin
                        core_a <= a_in;
                        core_b <= b_in;
                        ecnt   <= '0;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    ecnt <= ecnt + ECNT_W'(1);
                    if (ecnt == ECNT_W'(CORE_LAT - 1)) begin
                        core_c <= core_d;
                        kcnt   <= kcnt + CNT_W'(1);
                        if (kcnt == num_k_q - CNT_W'(1)) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state <= WAIT_OP;
                        end
                    end
                end
                FIN: begin
                    d_out_q <= core_c;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
